// File: rtl/synthesijer_fp_rx_pkg.sv
// Shared constants and helpers for the floating-point result receiver.
package synthesijer_fp_rx_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int MIN_DEPTH     = 2;
  localparam int MAX_DEPTH     = 16;

  // A legal depth is a power of two within the supported range.
  function automatic bit depth_legal(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/synthesijer_fp_rx_fifo.sv
// First-word fall-through register FIFO; a write into a full FIFO is legal
// only when the head is popped in the same cycle (the caller gates this).
module synthesijer_fp_rx_fifo
  import synthesijer_fp_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic [ptr_w(DEPTH):0] level_o
);

  localparam int            PW       = ptr_w(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   LVL_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   LVL_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_en_i ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en_i ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    level_d  = level_q;
    case ({wr_en_i, rd_en_i})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, intentionally left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (level_q != '0);
  assign full_o    = (level_q == LVL_FULL);
  assign level_o   = level_q;

endmodule

// File: rtl/synthesijer_fp_result_rx.sv
// Credit-gated result receiver for fixed-latency FP operators.
// Optional feature macro: SYNTHESIJER_FP_RX_ERR_CHECK_EN (sticky protocol error).
module synthesijer_fp_result_rx
  import synthesijer_fp_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  op_nd,
  input  logic                  op_valid,
  input  logic [WIDTH-1:0]      op_result,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  input  logic                  res_ready,
  output logic [ptr_w(DEPTH):0] level,
  output logic                  err
);

  localparam int          PW      = ptr_w(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0] CNT_MAX = (PW + 1)'(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("synthesijer_fp_result_rx: DEPTH must be a power of two in 2..16");
  end

  logic        issue_s, pop_s, full_s, wr_en_s;
  logic [PW:0] outstanding_q, outstanding_d;

  // Credits are held from issue until the consumer pops the result.
  assign req_ready = (outstanding_q != CNT_MAX);
  assign issue_s   = req_valid & req_ready;
  assign op_nd     = issue_s;
  assign pop_s     = res_valid & res_ready;
  assign wr_en_s   = op_valid & (~full_s | pop_s);

  // Outstanding credit next-state; saturates at zero against stray beats.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({issue_s, pop_s})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = (outstanding_q != '0) ? (outstanding_q - CNT_ONE) : outstanding_q;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Outstanding credit register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

`ifdef SYNTHESIJER_FP_RX_ERR_CHECK_EN
  logic [PW:0] inflight_q, inflight_d;
  logic        err_q, err_d;

  // Operations in the operator pipeline and the sticky error flag.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue_s, op_valid})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = (inflight_q != '0) ? (inflight_q - CNT_ONE) : inflight_q;
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q
          | (op_valid & (inflight_q == '0))
          | (op_valid & full_s & ~pop_s);
  end

  // In-flight counter and error register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  synthesijer_fp_rx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_en_i  (wr_en_s),
    .wr_data_i(op_result),
    .rd_en_i  (pop_s),
    .rd_data_o(res_data),
    .valid_o  (res_valid),
    .full_o   (full_s),
    .level_o  (level)
  );

endmodule

// File: tb/tb_synthesijer_fp_result_rx.sv
// Directed bench for synthesijer_fp_result_rx (DEPTH 4 main instance, DEPTH 8 for streaming).
module tb_synthesijer_fp_result_rx;

  localparam int W = 64;

`ifdef SYNTHESIJER_FP_RX_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req_valid, req_ready, op_nd, op_valid, res_valid, res_ready, err;
  logic [W-1:0] op_result, res_data;
  logic [2:0]   level;

  logic         s_req_valid, s_req_ready, s_op_nd, s_op_valid, s_res_valid, s_res_ready, s_err;
  logic [W-1:0] s_op_result, s_res_data;
  logic [3:0]   s_level;

  int n_pass = 0;
  int n_total = 0;

  synthesijer_fp_result_rx #(.WIDTH(W), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .op_nd(op_nd),
    .op_valid(op_valid), .op_result(op_result), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .level(level), .err(err)
  );

  synthesijer_fp_result_rx #(.WIDTH(W), .DEPTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready), .op_nd(s_op_nd),
    .op_valid(s_op_valid), .op_result(s_op_result), .res_valid(s_res_valid), .res_data(s_res_data),
    .res_ready(s_res_ready), .level(s_level), .err(s_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (level !== 3'd0) $display("FAIL por_level: got %0d want 0", level); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL por_req_ready: got %b want 1", req_ready); else n_pass++;
    n_total++; if (res_valid !== 1'b0 || op_nd !== 1'b0 || err !== 1'b0)
      $display("FAIL por_flags: got res_valid=%b op_nd=%b err=%b want 0 0 0", res_valid, op_nd, err); else n_pass++;
    tick(); tick();
    reset = 1'b1;
    tick();
    req_valid = 1'b1;
    tick(); tick(); tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op_valid = 1'b1; op_result = 64'h1000 + 64'(i);
      tick();
    end
    op_valid = 1'b0;
    #1;
    n_total++; if (level !== 3'd3) $display("FAIL midrst_pre_level: got %0d want 3", level); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (level !== 3'd0) $display("FAIL midrst_level: got %0d want 0", level); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL midrst_res_valid: got %b want 0", res_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL midrst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL midrst_err: got %b want 0", err); else n_pass++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid = 1'b1;
    #1;
    n_total++; if (op_nd !== 1'b1) $display("FAIL single_nd: got %b want 1", op_nd); else n_pass++;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    op_valid = 1'b1; op_result = 64'h4008_0000_0000_0000;
    #1;
    n_total++; if (res_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", res_valid); else n_pass++;
    tick();
    op_valid = 1'b0; res_ready = 1'b1;
    #1;
    n_total++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", res_valid); else n_pass++;
    n_total++; if (res_data !== 64'h4008_0000_0000_0000)
      $display("FAIL single_data: got %h want 4008000000000000", res_data); else n_pass++;
    tick();
    res_ready = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL single_after_pop: got req_ready=%b res_valid=%b want 1 0", req_ready, res_valid); else n_pass++;
  endtask

  task automatic test_credit_stall();
    res_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (op_nd !== 1'b1) $display("FAIL stall_issue%0d: got op_nd=%b want 1", i, op_nd); else n_pass++;
      tick();
    end
    #1;
    n_total++; if (req_ready !== 1'b0 || op_nd !== 1'b0)
      $display("FAIL stall_blocked: got req_ready=%b op_nd=%b want 0 0", req_ready, op_nd); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; op_result = 64'hA0 + 64'(i);
      tick();
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    n_total++; if (op_nd !== 1'b0 || res_data !== 64'hA0)
      $display("FAIL stall_pop_cycle: got op_nd=%b data=%h want 0 a0", op_nd, res_data); else n_pass++;
    tick();
    res_ready = 1'b0;
    #1;
    n_total++; if (op_nd !== 1'b1) $display("FAIL stall_credit_return: got op_nd=%b want 1", op_nd); else n_pass++;
    tick();
    req_valid = 1'b0;
    op_valid = 1'b1; op_result = 64'hA4;
    tick();
    op_valid = 1'b0;
    #1;
    n_total++; if (level !== 3'd4) $display("FAIL stall_full_level: got %0d want 4", level); else n_pass++;
  endtask

  task automatic test_simultaneous();
    op_valid = 1'b1; op_result = 64'hA5; res_ready = 1'b1;
    #1;
    n_total++; if (res_data !== 64'hA1) $display("FAIL simul_head: got %h want a1", res_data); else n_pass++;
    tick();
    op_valid = 1'b0; res_ready = 1'b0;
    #1;
    n_total++; if (level !== 3'd4) $display("FAIL simul_full_level: got %0d want 4", level); else n_pass++;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (res_data !== 64'hA2 + 64'(i))
        $display("FAIL simul_order%0d: got %h want %h", i, res_data, 64'hA2 + 64'(i)); else n_pass++;
      tick();
    end
    res_ready = 1'b0;
    #1;
    n_total++; if (res_valid !== 1'b0) $display("FAIL simul_drained: got %b want 0", res_valid); else n_pass++;
    // outstanding 3, level 1, then issue and pop together
    req_valid = 1'b1;
    tick(); tick(); tick();
    req_valid = 1'b0;
    op_valid = 1'b1; op_result = 64'hB0;
    tick();
    op_valid = 1'b0; req_valid = 1'b1; res_ready = 1'b1;
    #1;
    n_total++; if (op_nd !== 1'b1 || res_data !== 64'hB0)
      $display("FAIL simul_issue_pop: got op_nd=%b data=%h want 1 b0", op_nd, res_data); else n_pass++;
    tick();
    res_ready = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL simul_outstanding_held: got req_ready=%b want 1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL simul_outstanding_full: got req_ready=%b want 0", req_ready); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      op_valid = 1'b1; op_result = 64'hB0 + 64'(i);
      tick();
    end
    op_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    res_ready = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b1 || level !== 3'd0)
      $display("FAIL simul_final: got req_ready=%b level=%0d want 1 0", req_ready, level); else n_pass++;
  endtask

  task automatic test_stream();
    logic         pv [6];
    logic [W-1:0] pd [6];
    logic         nd;
    int issued = 0;
    int got = 0;
    int stalls = 0;
    for (int k = 0; k < 6; k++) begin pv[k] = 1'b0; pd[k] = '0; end
    s_res_ready = 1'b1;
    for (int c = 0; c < 130; c++) begin
      s_op_valid = pv[5]; s_op_result = pd[5];
      s_req_valid = (issued < 100);
      #1;
      if (s_res_valid) begin
        n_total++; if (s_res_data !== 64'h3FF0_0000_0000_0000 + 64'(got))
          $display("FAIL stream_data%0d: got %h want %h", got, s_res_data, 64'h3FF0_0000_0000_0000 + 64'(got)); else n_pass++;
        got++;
      end
      nd = s_op_nd;
      if (s_req_valid && !nd) stalls++;
      tick();
      for (int k = 5; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
      pv[0] = nd; pd[0] = 64'h3FF0_0000_0000_0000 + 64'(issued);
      if (nd) issued++;
    end
    s_op_valid = 1'b0; s_req_valid = 1'b0; s_res_ready = 1'b0;
    #1;
    n_total++; if (got != 100) $display("FAIL stream_count: got %0d want 100", got); else n_pass++;
    n_total++; if (stalls != 0) $display("FAIL stream_stalls: got %0d want 0", stalls); else n_pass++;
    n_total++; if (s_err !== 1'b0 || s_level !== 4'd0)
      $display("FAIL stream_end: got err=%b level=%0d want 0 0", s_err, s_level); else n_pass++;
  endtask

  task automatic test_error();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    op_valid = 1'b1; op_result = 64'hE0;
    #1;
    n_total++; if (err !== 1'b0) $display("FAIL err_before: got %b want 0", err); else n_pass++;
    tick();
    op_valid = 1'b0;
    #1;
    n_total++; if (err !== ERR_EXP) $display("FAIL err_unexpected: got %b want %b", err, ERR_EXP); else n_pass++;
    tick(); tick(); tick();
    n_total++; if (err !== ERR_EXP) $display("FAIL err_sticky: got %b want %b", err, ERR_EXP); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      op_valid = 1'b1; op_result = 64'hE0 + 64'(i);
      tick();
    end
    op_valid = 1'b0;
    #1;
    n_total++; if (level !== 3'd4) $display("FAIL err_overflow_level: got %0d want 4", level); else n_pass++;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (res_data !== 64'hE0 + 64'(i))
        $display("FAIL err_keep%0d: got %h want %h", i, res_data, 64'hE0 + 64'(i)); else n_pass++;
      tick();
    end
    res_ready = 1'b0;
    #1;
    n_total++; if (res_valid !== 1'b0) $display("FAIL err_dropped: got res_valid=%b want 0", res_valid); else n_pass++;
    n_total++; if (err !== ERR_EXP) $display("FAIL err_final: got %b want %b", err, ERR_EXP); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; op_valid = 1'b0; op_result = '0; res_ready = 1'b0;
    s_req_valid = 1'b0; s_op_valid = 1'b0; s_op_result = '0; s_res_ready = 1'b0;
    test_reset();
    test_single();
    test_credit_stall();
    test_simultaneous();
    test_stream();
    test_error();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
